// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg
// Shared definitions for the FIFO-fed UART transmitter.
//   state_t               : transmitter FSM states. PARITY is always declared
//                           but only reachable when FIFO_UART_TX_PARITY_EN
//                           is defined.
//   DEFAULT_WIDTH         : default data word width (bits per frame).
//   DEFAULT_CLKS_PER_BIT  : default clk cycles per serial bit.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    localparam int DEFAULT_WIDTH        = 16;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// uart_bit_timer
// Baud counter for the serial transmitter. Counts 0..CLKS_PER_BIT-1 and
// wraps; bit_tick is high on the final cycle of every bit period.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   clear    in   holds the counter at 0 (used outside a frame so the
//                 first bit period starts cleanly on entering START)
//   bit_tick out  high during the last cycle of a bit period
module uart_bit_timer
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] baud_cnt;

    // Decoded from the counter register, so no input reaches it combinationally.
    assign bit_tick = (baud_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            baud_cnt <= '0;
        end else if (bit_tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Pops words from a sync_fifo read port and sends each as an asynchronous
// serial frame: start bit, Width data bits LSB-first, stop bit.
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even-parity
// bit between the last data bit and the stop bit.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   en          in   permits new words to be popped (a frame in flight
//                    always finishes)
//   fifo_empty  in   sync_fifo empty flag
//   fifo_dout   in   sync_fifo read data, valid the cycle after fifo_r_enb
//   fifo_r_enb  out  sync_fifo read enable, one-cycle pulse per word
//   tx          out  serial line, idles high
//   busy        out  high whenever the FSM is not IDLE
//   word_done   out  one-cycle pulse on the last cycle of each stop bit
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int Width        = DEFAULT_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [Width-1:0] fifo_dout,
    output logic             fifo_r_enb,
    output logic             tx,
    output logic             busy,
    output logic             word_done
);

    localparam int BIT_W = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(Width - 1);

    state_t           state;
    state_t           state_next;
    logic [Width-1:0] shift_reg;
    logic [BIT_W-1:0] bit_cnt;
    logic             bit_tick;
    logic             timer_clear;
    logic             tx_next;
    logic             last_data_bit;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    // The baud counter is held at 0 outside a frame, so START always gets a
    // full bit period regardless of how the previous frame ended.
    assign timer_clear   = (state == IDLE) || (state == POP) || (state == LOAD);
    assign last_data_bit = bit_tick && (bit_cnt == LAST_BIT);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                if (en && !fifo_empty) begin
                    state_next = POP;
                end
            end
            POP: begin
                state_next = LOAD;
            end
            LOAD: begin
                state_next = START;
            end
            START: begin
                tx_next = 1'b0;
                if (bit_tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (last_data_bit) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
            PARITY: begin
`ifdef FIFO_UART_TX_PARITY_EN
                tx_next = parity_bit;
                if (bit_tick) begin
                    state_next = STOP;
                end
`else
                state_next = STOP;
`endif
            end
            STOP: begin
                // Back-to-back frames go straight to POP; the only idle-high
                // gap on the line is then the POP and LOAD cycles.
                if (bit_tick) begin
                    state_next = (en && !fifo_empty) ? POP : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read enable and busy are decoded straight from the state register so
    // the pop pulse lines up with the cycle the FSM spends in POP.
    assign fifo_r_enb = (state == POP);
    assign busy       = (state != IDLE);

    // tx and word_done are registered one cycle behind the state decode; the
    // line therefore falls three edges after the pop request is sampled, and
    // word_done coincides with the final cycle of the stop bit on the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx        <= 1'b1;
            word_done <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            tx        <= tx_next;
            word_done <= (state == STOP) && bit_tick;
            case (state)
                LOAD: begin
                    shift_reg <= fifo_dout;
                    bit_cnt   <= '0;
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    // Even parity is taken from the word as loaded, before any shifting.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_bit <= 1'b0;
        end else if (state == LOAD) begin
            parity_bit <= ^fifo_dout;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
// Bench for fifo_uart_tx (Width=16, CLKS_PER_BIT=4) fed by a small
// behavioural 8-deep synchronous FIFO. Words written by the stimulus are
// queued as expected frames; a serial decoder process pops and compares
// each frame it sees on tx. Honors FIFO_UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int W     = 16;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = W + 3;
`else
    localparam int NBITS = W + 2;
`endif
    localparam int FRAME = NBITS * CPB;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         en    = 1'b0;
    logic         fifo_empty;
    logic [W-1:0] fifo_dout;
    logic         fifo_r_enb;
    logic         tx;
    logic         busy;
    logic         word_done;

    logic         wr_en   = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] mem [DEPTH];
    logic [3:0]   cnt = 4'd0;
    logic [2:0]   rp  = 3'd0;
    logic [2:0]   wp  = 3'd0;

    int      n_checks     = 0;
    int      n_fail       = 0;
    int      rd_pulses    = 0;
    int      wd_pulses    = 0;
    int      burst_frames = 0;
    logic    gap_check_en = 1'b0;
    logic    prev_renb    = 1'b0;
    longint  cyc          = 0;
    longint  last_t0      = 0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .Width       (W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_r_enb(fifo_r_enb),
        .tx        (tx),
        .busy      (busy),
        .word_done (word_done)
    );

    // Behavioural sync_fifo: registered read data, flags from the count.
    wire fifo_rd = fifo_r_enb && (cnt != 4'd0);
    wire fifo_wr = wr_en && (cnt != 4'd8);
    assign fifo_empty = (cnt == 4'd0);

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_dout <= mem[rp];
            rp        <= rp + 3'd1;
        end
        if (fifo_wr) begin
            mem[wp] <= wr_data;
            wp      <= wp + 3'd1;
        end
        cnt <= cnt + {3'b0, fifo_wr} - {3'b0, fifo_rd};
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read-enable watcher: pulses must be single-cycle and never hit an empty FIFO.
    always @(negedge clk) begin
        if (fifo_r_enb === 1'b1) begin
            rd_pulses++;
            chk("renb_single_cycle", {31'b0, prev_renb}, 32'd0);
            chk("renb_not_empty", {31'b0, fifo_empty}, 32'd0);
        end
        if (word_done === 1'b1) wd_pulses++;
        prev_renb <= fifo_r_enb;
    end

    // Serial decoder: entered at the first negedge where tx is low.
    task automatic decode_frame();
        logic [W-1:0] data;
        logic [W-1:0] expw;
        logic         stop;
        logic         aborted;
        longint       t0;
        int           b;
`ifdef FIFO_UART_TX_PARITY_EN
        logic         par;
        par = 1'b0;
`endif
        data    = '0;
        stop    = 1'b0;
        aborted = 1'b0;
        t0      = cyc;
        expw    = '0;
        chk("frame_expected", {31'b0, (exp_q.size() > 0)}, 32'd1);
        if (exp_q.size() > 0) expw = exp_q.pop_front();
        if (gap_check_en && burst_frames > 0)
            chk("b2b_start_spacing", 32'(t0 - last_t0), 32'(FRAME + 2));
        if (gap_check_en) burst_frames++;
        last_t0 = t0;
        for (int c = 1; c < FRAME; c++) begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                aborted = 1'b1;
                break;
            end
            if (c % CPB == 1) begin
                b = c / CPB;
                if (b == 0) chk("start_bit", {31'b0, tx}, 32'd0);
                else if (b <= W) data[b-1] = tx;
`ifdef FIFO_UART_TX_PARITY_EN
                else if (b == W + 1) par = tx;
`endif
                else stop = tx;
            end
            if (c == FRAME - 2) chk("word_done_early", {31'b0, word_done}, 32'd0);
            if (c == FRAME - 1) chk("word_done_last_stop", {31'b0, word_done}, 32'd1);
        end
        if (!aborted) begin
            chk("frame_data", {16'b0, data}, {16'b0, expw});
`ifdef FIFO_UART_TX_PARITY_EN
            chk("parity_bit", {31'b0, par}, {31'b0, ^expw});
`endif
            chk("stop_bit", {31'b0, stop}, 32'd1);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && reset === 1'b0) decode_frame();
        end
    end

    task automatic write_word(input logic [W-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        exp_q.push_back(w);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_busy(input int maxc, input string name);
        for (int i = 0; i < maxc && busy !== 1'b1; i++) @(negedge clk);
        chk({name, "_busy_seen"}, {31'b0, (busy === 1'b1)}, 32'd1);
    endtask

    task automatic wait_not_busy(input int maxc, input string name);
        for (int i = 0; i < maxc && busy !== 1'b0; i++) @(negedge clk);
        chk({name, "_idle_seen"}, {31'b0, (busy === 1'b0)}, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int rd0;
        int wd0;

        // Reset with FIFO empty and en high.
        reset = 1'b1;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_tx", {31'b0, tx}, 32'd1);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_renb", {31'b0, fifo_r_enb}, 32'd0);
        chk("reset_word_done", {31'b0, word_done}, 32'd0);
        reset = 1'b0;
        rd0 = rd_pulses;
        repeat (20) @(negedge clk);
        chk("empty_no_pop", 32'(rd_pulses - rd0), 32'd0);
        chk("empty_idle_tx", {31'b0, tx}, 32'd1);

        // Single word: pop latency and full frame.
        rd0 = rd_pulses;
        wd0 = wd_pulses;
        write_word(16'hA5C3);
        @(negedge clk);
        chk("pop_pulse_high", {31'b0, fifo_r_enb}, 32'd1);
        @(negedge clk);
        chk("pop_pulse_low", {31'b0, fifo_r_enb}, 32'd0);
        chk("tx_high_in_load", {31'b0, tx}, 32'd1);
        @(negedge clk);
        chk("tx_high_before_fall", {31'b0, tx}, 32'd1);
        @(negedge clk);
        chk("tx_fall_latency", {31'b0, tx}, 32'd0);
        wait_not_busy(FRAME + 20, "single");
        repeat (3) @(negedge clk);
        chk("single_pop_count", 32'(rd_pulses - rd0), 32'd1);
        chk("single_word_done_count", 32'(wd_pulses - wd0), 32'd1);
        chk("single_fifo_empty", {31'b0, fifo_empty}, 32'd1);

        // Back-to-back burst of 8 words from a full FIFO.
        en  = 1'b0;
        wd0 = wd_pulses;
        for (int i = 0; i < 8; i++) write_word(W'(i));
        chk("fifo_full", {28'b0, cnt}, 32'd8);
        gap_check_en = 1'b1;
        burst_frames = 0;
        en = 1'b1;
        wait_busy(10, "burst");
        wait_not_busy(8 * (FRAME + 2) + 20, "burst");
        repeat (3) @(negedge clk);
        gap_check_en = 1'b0;
        chk("burst_frames", 32'(burst_frames), 32'd8);
        chk("burst_word_done_count", 32'(wd_pulses - wd0), 32'd8);
        chk("burst_fifo_empty", {31'b0, fifo_empty}, 32'd1);

        // en dropped mid-frame: current frame completes, second word stays.
        en  = 1'b0;
        wd0 = wd_pulses;
        write_word(16'h1234);
        write_word(16'hBEEF);
        en = 1'b1;
        wait_busy(10, "gate");
        repeat (20) @(negedge clk);
        en = 1'b0;
        wait_not_busy(FRAME + 20, "gate");
        repeat (10) @(negedge clk);
        chk("gate_fifo_not_empty", {31'b0, fifo_empty}, 32'd0);
        chk("gate_busy_low", {31'b0, busy}, 32'd0);
        chk("gate_one_word_done", 32'(wd_pulses - wd0), 32'd1);
        en = 1'b1;
        wait_busy(10, "gate_resume");
        wait_not_busy(FRAME + 20, "gate_resume");
        repeat (3) @(negedge clk);
        chk("gate_resume_done", 32'(wd_pulses - wd0), 32'd2);
        chk("gate_resume_empty", {31'b0, fifo_empty}, 32'd1);

        // Reset during data bit 5.
        write_word(16'h5A5A);
        for (int i = 0; i < 20 && tx !== 1'b0; i++) @(negedge clk);
        chk("rst_frame_started", {31'b0, (tx === 1'b0)}, 32'd1);
        repeat (26) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", {31'b0, tx}, 32'd1);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_renb", {31'b0, fifo_r_enb}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd0 = rd_pulses;
        repeat (20) @(negedge clk);
        chk("rst_no_pop_after", 32'(rd_pulses - rd0), 32'd0);
        chk("rst_idle_tx", {31'b0, tx}, 32'd1);
        chk("rst_idle_busy", {31'b0, busy}, 32'd0);

        // Parity-sensitive words (odd and even number of ones).
        wd0 = wd_pulses;
        write_word(16'h0001);
        wait_busy(10, "par1");
        wait_not_busy(FRAME + 20, "par1");
        write_word(16'h0003);
        wait_busy(10, "par2");
        wait_not_busy(FRAME + 20, "par2");
        repeat (3) @(negedge clk);
        chk("par_word_done_count", 32'(wd_pulses - wd0), 32'd2);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
